// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the fetch/LSU memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Values double as bit positions in the arbiter's request/grant vectors.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    localparam port_id_t RESET_LAST_GRANT = PORT_D;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant with a last-grant flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    port_id_t last_grant_q;
    port_id_t last_grant_d;

    always_comb begin
        grant_o      = req_i;
        last_grant_d = last_grant_q;
        // A tie goes to the port that did not win last time.
        if (req_i == 2'b11) begin
            grant_o = (last_grant_q == PORT_I) ? 2'b10 : 2'b01;
        end
        if (advance_i && (grant_o != 2'b00)) begin
            last_grant_d = grant_o[1] ? PORT_D : PORT_I;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= RESET_LAST_GRANT;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between fetch and LSU ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    output logic             i_req_ready,
    input  logic [WIDTH-1:0] i_req_addr,
    output logic             i_resp_valid,
    output logic [WIDTH-1:0] i_resp_data,
    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic [WIDTH-1:0] d_req_addr,
    input  logic             d_req_we,
    input  logic [WIDTH-1:0] d_req_wdata,
    output logic             d_resp_valid,
    output logic [WIDTH-1:0] d_resp_data,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rdata
);

    arb_state_t       state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    port_id_t         owner_q, owner_d;

    logic [1:0]       w_grant;
    logic             w_accept_en;
    logic             w_accept;
    logic             w_resp;

    assign w_accept_en = (state_q == ARB_IDLE) || (state_q == ARB_RESP);
    assign w_accept    = w_accept_en && (i_req_valid || d_req_valid);

    rr_arbiter2 u_rr_arbiter2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     ({d_req_valid, i_req_valid}),
        .advance_i (w_accept),
        .grant_o   (w_grant)
    );

    assign i_req_ready = w_accept_en && w_grant[PORT_I];
    assign d_req_ready = w_accept_en && w_grant[PORT_D];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE:   state_d = w_accept ? ARB_ACCESS : ARB_IDLE;
            ARB_ACCESS: state_d = ARB_RESP;
            ARB_RESP:   state_d = w_accept ? ARB_ACCESS : ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
        if (w_accept) begin
            if (w_grant[PORT_D]) begin
                addr_d  = d_req_addr;
                wdata_d = d_req_wdata;
                we_d    = d_req_we;
                owner_d = PORT_D;
            end else begin
                addr_d  = i_req_addr;
                wdata_d = '0;
                we_d    = 1'b0;
                owner_d = PORT_I;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            owner_q <= PORT_I;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            owner_q <= owner_d;
        end
    end

    // Memory returns read data one cycle after the address, i.e. during ARB_RESP.
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_we       = (state_q == ARB_ACCESS) && we_q;
    assign w_resp       = (state_q == ARB_RESP);
    assign i_resp_valid = w_resp && (owner_q == PORT_I);
    assign d_resp_valid = w_resp && (owner_q == PORT_D);
    assign i_resp_data  = i_resp_valid ? mem_rdata : '0;
    assign d_resp_data  = (d_resp_valid && !we_q) ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Randomized self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_req_valid = 1'b0;
    logic         i_req_ready;
    logic [W-1:0] i_req_addr = '0;
    logic         i_resp_valid;
    logic [W-1:0] i_resp_data;
    logic         d_req_valid = 1'b0;
    logic         d_req_ready;
    logic [W-1:0] d_req_addr = '0;
    logic         d_req_we = 1'b0;
    logic [W-1:0] d_req_wdata = '0;
    logic         d_resp_valid;
    logic [W-1:0] d_resp_data;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_we;
    logic [W-1:0] mem_rdata = '0;

    mem_arbiter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .i_req_ready  (i_req_ready),
        .i_req_addr   (i_req_addr),
        .i_resp_valid (i_resp_valid),
        .i_resp_data  (i_resp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_req_we     (d_req_we),
        .d_req_wdata  (d_req_wdata),
        .d_resp_valid (d_resp_valid),
        .d_resp_data  (d_resp_data),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_val(input int idx);
        return (idx * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    // Simulation memory: registered read, write on mem_we.
    logic [W-1:0] tb_mem     [64];
    logic         tb_mem_vld [64];
    always @(posedge clk) begin
        mem_rdata <= tb_mem_vld[mem_addr[7:2]] ? tb_mem[mem_addr[7:2]] : init_val(int'(mem_addr[7:2]));
        if (mem_we) begin
            tb_mem[mem_addr[7:2]]     <= mem_wdata;
            tb_mem_vld[mem_addr[7:2]] <= 1'b1;
        end
    end

    // Transaction-level reference model.
    typedef struct {
        logic     port;   // 0 = fetch, 1 = data
        logic     we;
        int       idx;
        int       due;
    } txn_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_acc = -10;
    logic         last_grant = 1'b1;
    logic         last_we = 1'b0;
    logic [W-1:0] last_addr = '0;
    logic [W-1:0] last_wdata = '0;
    logic [W-1:0] ref_mem [64];
    txn_t         pend [$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        last_acc   = -10;
        last_grant = 1'b1;
        last_we    = 1'b0;
        pend.delete();
    endtask

    task automatic cycle(input logic iv, input logic [W-1:0] ia,
                         input logic dv, input logic dwe,
                         input logic [W-1:0] da, input logic [W-1:0] dw);
        logic   allowed, ei, ed, in_access;
        logic   ev_i, ev_d;
        logic [W-1:0] ed_i, ed_d;
        txn_t   t;
        @(negedge clk);
        i_req_valid = iv; i_req_addr = ia;
        d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dw;
        #1;
        in_access = (cyc == last_acc + 1);
        allowed   = !in_access;
        if (!allowed)       begin ei = 1'b0; ed = 1'b0; end
        else if (iv && dv)  begin ei = last_grant; ed = !last_grant; end
        else                begin ei = iv; ed = dv; end
        check("i_req_ready", W'(i_req_ready), W'(ei));
        check("d_req_ready", W'(d_req_ready), W'(ed));
        check("mem_we", W'(mem_we), W'(in_access && last_we));
        if (in_access) begin
            check("mem_addr", mem_addr, last_addr);
            if (last_we) check("mem_wdata", mem_wdata, last_wdata);
        end
        ev_i = 1'b0; ev_d = 1'b0; ed_i = '0; ed_d = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            t = pend.pop_front();
            if (t.port) begin ev_d = 1'b1; ed_d = t.we ? '0 : ref_mem[t.idx]; end
            else        begin ev_i = 1'b1; ed_i = ref_mem[t.idx]; end
        end
        check("i_resp_valid", W'(i_resp_valid), W'(ev_i));
        check("i_resp_data", i_resp_data, ed_i);
        check("d_resp_valid", W'(d_resp_valid), W'(ev_d));
        check("d_resp_data", d_resp_data, ed_d);
        @(posedge clk);
        if (in_access && last_we) ref_mem[last_addr[7:2]] = last_wdata;
        if (ei || ed) begin
            last_grant = ed;
            last_acc   = cyc;
            last_we    = ed && dwe;
            last_addr  = ed ? da : ia;
            last_wdata = dw;
            t.port = ed; t.we = ed && dwe; t.idx = int'(last_addr[7:2]); t.due = cyc + 2;
            pend.push_back(t);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) ref_mem[k] = init_val(k);

        // Reset with both requesters asserting.
        rst_n = 1'b0; i_req_valid = 1'b1; d_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_we", W'(mem_we), '0);
        check("rst_i_resp_valid", W'(i_resp_valid), '0);
        check("rst_d_resp_valid", W'(d_resp_valid), '0);
        check("rst_i_ready_tie", W'(i_req_ready), W'(1));
        check("rst_d_ready_tie", W'(d_req_ready), '0);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();

        // Contention from reset: fetch addr 0 vs data read addr 8.
        for (int k = 0; k < 8; k++) cycle(1'b1, 32'd0, 1'b1, 1'b0, 32'd8, '0);
        idle(2);

        // Write 0xCAFEBABE to 4, then fetch it back.
        cycle(1'b0, '0, 1'b1, 1'b1, 32'd4, 32'hCAFE_BABE);
        idle(2);
        cycle(1'b1, 32'd4, 1'b0, 1'b0, '0, '0);
        idle(2);

        // Back-to-back data reads with valid held.
        cycle(1'b0, '0, 1'b1, 1'b0, 32'd0, '0);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'd4, '0);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'd4, '0);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'd8, '0);
        idle(3);

        // Reset during the access cycle of a write to 12.
        cycle(1'b0, '0, 1'b1, 1'b1, 32'd12, 32'hDEAD_BEEF);
        @(negedge clk);
        d_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", W'(mem_we), '0);
        @(negedge clk);
        #1;
        check("midrst_d_resp_valid", W'(d_resp_valid), '0);
        check("midrst_i_resp_valid", W'(i_resp_valid), '0);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, '0, 1'b1, 1'b0, 32'd12, '0);
        idle(2);

        // Fetch of an address the data port zeroed earlier.
        cycle(1'b0, '0, 1'b1, 1'b1, 32'd16, 32'h0);
        idle(2);
        cycle(1'b1, 32'd16, 1'b0, 1'b0, '0, '0);
        idle(2);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(0, 99) < 60), W'({$urandom_range(0, 63), 2'b00}),
                  ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                  W'({$urandom_range(0, 63), 2'b00}), W'($urandom));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
